// File: rtl/fetch_stage_queued.sv
`default_nettype none
// ============================================================================
// fetch_stage_queued : PC owner issuing sequential imem reads into a FIFO that
//                      feeds decode over valid/ready; redirect flushes it.
// Rev 1.0
// ============================================================================
module fetch_stage_queued #(
  parameter int            AW       = 16,
  parameter int            IW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [AW-1:0]              redirect_addr,
  output logic                       imem_req,
  output logic [AW-1:0]              imem_addr,
  input  logic [IW-1:0]              imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IW-1:0]              out_instr,
  output logic [AW-1:0]              out_pc,
  output logic [AW-1:0]              out_pc_next,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_OCC_W = c_CNT_W + 1;

  logic [AW-1:0]      r_pc;
  logic [AW-1:0]      r_infl_pc;
  logic               r_infl;
  logic [IW-1:0]      r_instr_q [DEPTH];
  logic [AW-1:0]      r_pc_q    [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [c_OCC_W-1:0] w_occ_next;

  assign w_pop  = (r_count != '0) & out_ready;
  assign w_push = r_infl & ~redirect_valid;

  // Slots still claimed after this cycle's pop; the outstanding read already owns one.
  assign w_occ_next = {1'b0, r_count} + c_OCC_W'(r_infl) - c_OCC_W'(w_pop);

  // Gating with the reset pin keeps the strobe low while reset is held.
  assign w_issue = reset & fetch_en & ~redirect_valid & (w_occ_next < c_OCC_W'(DEPTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_infl_pc <= '0;
      r_infl    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc_q[i]    <= '0;
      end
    end else if (redirect_valid) begin
      r_pc    <= redirect_addr;
      r_infl  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_infl <= w_issue;
      if (w_issue) begin
        r_pc      <= r_pc + AW'(1);
        r_infl_pc <= r_pc;
      end
      if (w_push) begin
        r_instr_q[r_wptr] <= imem_rdata;
        r_pc_q[r_wptr]    <= r_infl_pc;
        r_wptr            <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc;
  assign out_valid   = (r_count != '0);
  assign out_instr   = r_instr_q[r_rptr];
  assign out_pc      = r_pc_q[r_rptr];
  assign out_pc_next = r_pc_q[r_rptr] + AW'(1);
  assign q_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_queued.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage_queued : directed stimulus with a scoreboard-driven monitor.
// Rev 1.0
// ============================================================================
module tb_fetch_stage_queued;

  localparam int AW    = 16;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_next;
  logic [$clog2(DEPTH):0] q_count;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [AW-1:0] exp_next;
  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_req    = 0;

  fetch_stage_queued #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_next    (out_pc_next),
    .q_count        (q_count)
  );

  always #5 clock = ~clock;

  // Synchronous instruction memory: mem[a] = a + 0x100.
  always @(posedge clock) begin
    if (imem_req) imem_rdata <= imem_addr + 16'h0100;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [AW-1:0] start, input int n);
    exp_t x;
    logic [AW-1:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      x.pc    = p;
      x.instr = p + 16'h0100;
      sb.push_back(x);
      p = p + 16'h0001;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},    imem_req,    0);
    check({tag, "_imem_addr"},   imem_addr,   16'h0000);
    check({tag, "_out_valid"},   out_valid,   0);
    check({tag, "_out_instr"},   out_instr,   16'h0000);
    check({tag, "_out_pc"},      out_pc,      16'h0000);
    check({tag, "_out_pc_next"}, out_pc_next, 16'h0001);
    check({tag, "_q_count"},     q_count,     0);
  endtask

  // Redirect with the consumer stalled so no transfer coincides with the flush.
  task automatic redirect_to(input logic [AW-1:0] a, input logic fe, input int n_exp);
    out_ready = 1'b0;
    tick(1);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    fetch_en       = fe;
    sb.delete();
    push_stream(a, n_exp);
    tick(1);
    redirect_valid = 1'b0;
  endtask

  // Monitor: every completed transfer must match the scoreboard head.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (imem_req === 1'b1) n_req++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: out_pc=%h out_instr=%h required=none", out_pc, out_instr);
        end else begin
          e = sb.pop_front();
          exp_next = e.pc + 16'h0001;
          check("head_pc",      out_pc,      e.pc);
          check("head_instr",   out_instr,   e.instr);
          check("head_pc_next", out_pc_next, exp_next);
        end
        n_pop++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_addr = '0;
    #12;
    check_reset_outputs("rst");

    // 1: free-running stream from RESET_PC
    push_stream(16'h0000, 64);
    n_pop = 0;
    tick(1);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("t1_imem_req", imem_req, 1);
      check("t1_imem_addr", imem_addr, k);
    end
    check("t1_pops_min", (n_pop >= 5), 1);
    tick(1);
    out_ready = 1'b0; fetch_en = 1'b0;
    tick(3);

    // 2: consumer stalled from reset fills exactly DEPTH entries
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
    tick(2);
    sb.delete();
    push_stream(16'h0000, 64);
    n_req = 0; n_pop = 0;
    reset = 1'b1;
    tick(8);
    @(negedge clock);
    check("t2_q_count_full", q_count, 4);
    check("t2_imem_req_idle", imem_req, 0);
    check("t2_req_total", n_req, 4);
    check("t2_out_valid", out_valid, 1);
    tick(1);
    out_ready = 1'b1;
    n_pop = 0;
    tick(20);
    check("t2_sustained_pops", n_pop, 20);

    // 3: redirect while holding 3 entries with a read outstanding
    out_ready = 1'b0;
    tick(6);
    check("t3_q_count_full", q_count, 4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 16'h0040;
    @(negedge clock);
    check("t3_q_count_before", q_count, 3);
    check("t3_req_in_redirect", imem_req, 0);
    sb.delete();
    push_stream(16'h0040, 64);
    n_pop = 0;
    tick(1);
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("t3_q_count_after", q_count, 0);
    check("t3_imem_addr", imem_addr, 16'h0040);
    check("t3_imem_req", imem_req, 1);
    check("t3_out_valid", out_valid, 0);
    tick(10);
    check("t3_pops_min", (n_pop >= 5), 1);

    // 4: PC wrap through FFFF
    redirect_to(16'hFFFE, 1'b1, 64);
    out_ready = 1'b1;
    n_pop = 0;
    tick(8);
    check("t4_pops_min", (n_pop >= 3), 1);

    // 5: fetch_en dropped right after a single issue
    redirect_to(16'h0200, 1'b0, 1);
    fetch_en = 1'b1; out_ready = 1'b1;
    n_req = 0; n_pop = 0;
    tick(1);
    fetch_en = 1'b0;
    tick(8);
    check("t5_req_total", n_req, 1);
    check("t5_pop_total", n_pop, 1);
    check("t5_q_count", q_count, 0);
    check("t5_sb_drained", sb.size(), 0);

    // 6: async reset with the queue full
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(8);
    @(negedge clock);
    check("t6_q_count_full", q_count, 4);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    sb.delete();
    push_stream(16'h0000, 64);
    n_pop = 0;
    tick(2);
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    check("t6_restart_addr", imem_addr, 16'h0000);
    check("t6_restart_req", imem_req, 1);
    tick(10);
    check("t6_pops_min", (n_pop >= 5), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
